dmem_resp: RTL and testbench

Responder on the core's data-memory port. It receives the core's address, write data and byte strobes, and returns read data.
Serves a byte-strobed data RAM plus a small MMIO block containing a free-running 64-bit timer, a timer compare register and a tohost halt register.
Sits beside the core at top level; its halt_req output feeds the core's halted input.
Reads are combinational (single-cycle core); all state updates occur on the rising clock edge.

---
 rtl/dmem_resp.sv | 128 ++++++++++++
 tb/tb_dmem_resp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder for a single-cycle core: byte-strobed RAM plus an MMIO
// block holding a free-running 64-bit timer, its compare register and tohost.
module dmem_resp #(
    parameter int unsigned RamWords = 1024,
    parameter logic [31:0] MmioBase = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        halt_req,
    output logic        timer_irq,
    output logic [31:0] tohost,
    output logic        access_fault
);

    localparam int unsigned AddrBits = $clog2(RamWords);
    localparam logic [32:0] RamBytes = 33'(RamWords) * 33'd4;

    localparam logic [2:0] OffMtimeLo    = 3'd0;
    localparam logic [2:0] OffMtimeHi    = 3'd1;
    localparam logic [2:0] OffMtimecmpLo = 3'd2;
    localparam logic [2:0] OffMtimecmpHi = 3'd3;
    localparam logic [2:0] OffTohost     = 3'd4;

    logic                is_ram;
    logic                is_mmio;
    logic                wr_any;
    logic [AddrBits-1:0] word_idx;
    logic [2:0]          off;

    logic                mtime_lo_wr;
    logic                mtime_hi_wr;
    logic                cmp_lo_wr;
    logic                cmp_hi_wr;
    logic                tohost_wr;

    logic [63:0]         mtime;
    logic [63:0]         mtimecmp;
    logic [31:0]         tohost_next;

    logic [31:0]         ram [RamWords];

    // Overwrite only the strobed byte lanes of a 32-bit word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // RAM wins if the two windows ever overlap, so the decode stays one-hot.
    assign is_ram   = {1'b0, d_addr} < RamBytes;
    assign is_mmio  = !is_ram && (d_addr[31:5] == MmioBase[31:5]);
    assign wr_any   = |d_wstrb;
    assign word_idx = d_addr[AddrBits+1:2];
    assign off      = d_addr[4:2];

    assign mtime_lo_wr = is_mmio && wr_any && (off == OffMtimeLo);
    assign mtime_hi_wr = is_mmio && wr_any && (off == OffMtimeHi);
    assign cmp_lo_wr   = is_mmio && wr_any && (off == OffMtimecmpLo);
    assign cmp_hi_wr   = is_mmio && wr_any && (off == OffMtimecmpHi);
    assign tohost_wr   = is_mmio && wr_any && (off == OffTohost);

    assign tohost_next  = merge_bytes(tohost, d_wdata, d_wstrb);
    assign timer_irq    = mtime >= mtimecmp;
    assign access_fault = wr_any && !is_ram && !is_mmio;

    // NOTE: the RAM array has no reset; clearing it would force flops instead of
    // a memory macro. reset_n only gates the write enable here.
    always_ff @(posedge clk) begin
        if (reset_n && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (d_wstrb[i]) ram[word_idx][8*i +: 8] <= d_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values, which also gives read-before-write on the port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime    <= '0;
            mtimecmp <= '1;
            tohost   <= '0;
            halt_req <= 1'b0;
        end else begin
            if (mtime_lo_wr)
                mtime[31:0]  <= merge_bytes(mtime[31:0], d_wdata, d_wstrb);
            else if (mtime_hi_wr)
                mtime[63:32] <= merge_bytes(mtime[63:32], d_wdata, d_wstrb);
            else
                mtime <= mtime + 64'd1;

            if (cmp_lo_wr) mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], d_wdata, d_wstrb);
            if (cmp_hi_wr) mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], d_wdata, d_wstrb);

            if (tohost_wr && !halt_req) begin
                tohost <= tohost_next;
                if (tohost_next != 32'd0) halt_req <= 1'b1;
            end
        end
    end

    // NOTE: d_rdata gets a default before any branch so no latch is inferred.
    always_comb begin
        d_rdata = '0;
        if (is_ram) begin
            d_rdata = ram[word_idx];
        end else if (is_mmio) begin
            case (off)
                OffMtimeLo:    d_rdata = mtime[31:0];
                OffMtimeHi:    d_rdata = mtime[63:32];
                OffMtimecmpLo: d_rdata = mtimecmp[31:0];
                OffMtimecmpHi: d_rdata = mtimecmp[63:32];
                OffTohost:     d_rdata = tohost;
                default:       d_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: directed scenarios plus random traffic checked
// against a byte-addressed behavioural model of the memory map.
module tb_dmem_resp;

    localparam int unsigned RamWords = 1024;
    localparam logic [31:0] Mmio     = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        halt_req;
    logic        timer_irq;
    logic [31:0] tohost;
    logic        access_fault;

    dmem_resp #(.RamWords(RamWords), .MmioBase(Mmio)) dut (
        .clk(clk), .reset_n(reset_n), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .halt_req(halt_req),
        .timer_irq(timer_irq), .tohost(tohost), .access_fault(access_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [31:0] rmask;
        logic        halt;
        logic        irq;
        logic        fault;
        logic [31:0] tohost;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Reference model: RAM as sparse bytes, timer as a plain 64-bit count.
    logic [7:0]  m_ram[int];
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    logic [31:0] m_tohost;
    logic        m_halt;

    function automatic bit in_ram(input logic [31:0] a);
        return a < RamWords * 4;
    endfunction

    function automatic bit in_mmio(input logic [31:0] a);
        return !in_ram(a) && (a >= Mmio) && (a < Mmio + 32);
    endfunction

    task automatic model_reset();
        m_time   = 64'd0;
        m_cmp    = '1;
        m_tohost = 32'd0;
        m_halt   = 1'b0;
    endtask

    task automatic model_read(input logic [31:0] a, output logic [31:0] data,
                              output logic [31:0] mask);
        int base;
        data = 32'd0;
        mask = '1;
        if (in_ram(a)) begin
            base = int'(a - a % 4);
            for (int i = 0; i < 4; i++) begin
                if (m_ram.exists(base + i)) data[8*i +: 8] = m_ram[base + i];
                else mask[8*i +: 8] = 8'h00;
            end
        end else if (in_mmio(a)) begin
            case ((a - Mmio) / 4)
                0: data = m_time[31:0];
                1: data = m_time[63:32];
                2: data = m_cmp[31:0];
                3: data = m_cmp[63:32];
                4: data = m_tohost;
                default: data = 32'd0;
            endcase
        end
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] w,
                              input logic [3:0] s);
        bit          timer_written = 0;
        int          idx;
        logic [31:0] th;
        if (in_ram(a)) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) m_ram[int'(a - a % 4) + i] = w[8*i +: 8];
        end else if (in_mmio(a) && s != 4'd0) begin
            idx = int'((a - Mmio) / 4);
            if (idx <= 1) begin
                timer_written = 1;
                for (int i = 0; i < 4; i++)
                    if (s[i]) m_time[idx*32 + 8*i +: 8] = w[8*i +: 8];
            end else if (idx <= 3) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) m_cmp[(idx-2)*32 + 8*i +: 8] = w[8*i +: 8];
            end else if (idx == 4 && !m_halt) begin
                th = m_tohost;
                for (int i = 0; i < 4; i++)
                    if (s[i]) th[8*i +: 8] = w[8*i +: 8];
                m_tohost = th;
                if (th != 0) m_halt = 1'b1;
            end
        end
        if (!timer_written) m_time = m_time + 64'd1;
    endtask

    task automatic push_exp(input string nm);
        exp_t e;
        e.name = nm;
        model_read(d_addr, e.rdata, e.rmask);
        e.halt   = m_halt;
        e.irq    = (m_time >= m_cmp);
        e.fault  = (d_wstrb != 4'd0) && !in_ram(d_addr) && !in_mmio(d_addr);
        e.tohost = m_tohost;
        q.push_back(e);
    endtask

    // One bus cycle, entered and left just after a rising edge.
    task automatic cycle(input logic [31:0] a, input logic [31:0] w,
                         input logic [3:0] s, input string nm);
        d_addr  = a;
        d_wdata = w;
        d_wstrb = s;
        push_exp(nm);
        @(posedge clk);
        if (reset_n) model_edge(a, w, s);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp, input logic [31:0] mask);
        n_total++;
        if ((act & mask) !== (exp & mask))
            $display("FAIL %s: got %h, expected %h (mask %h)", nm, act, exp, mask);
        else
            n_pass++;
    endtask

    // Monitor: compares the DUT's combinational outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.name, ".rdata"},  d_rdata,             e.rdata,       e.rmask);
                check({e.name, ".halt"},   {31'd0, halt_req},    {31'd0, e.halt},  32'd1);
                check({e.name, ".irq"},    {31'd0, timer_irq},   {31'd0, e.irq},   32'd1);
                check({e.name, ".fault"},  {31'd0, access_fault},{31'd0, e.fault}, 32'd1);
                check({e.name, ".tohost"}, tohost,               e.tohost,      '1);
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [31:0] cmp_lo;
        int          kind;
        int          offs;

        reset_n = 1'b0;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
        d_wstrb = 4'd0;
        model_reset();
        @(posedge clk);
        #1;

        cycle(Mmio + 0,  32'd0, 4'h0, "rst_mtime_lo");
        cycle(Mmio + 8,  32'd0, 4'h0, "rst_mtimecmp_lo");
        cycle(32'h4000_0000, 32'h1234_5678, 4'hF, "rst_fault_no_write");
        reset_n = 1'b1;

        // Timer runs from zero after reset.
        for (int i = 0; i < 4; i++) cycle(Mmio + 0, 32'd0, 4'h0, "mtime_run");

        // RAM byte lanes and read-before-write.
        cycle(32'h10, 32'hDEAD_BEEF, 4'hF,    "ram_wr_full");
        cycle(32'h10, 32'h0000_00AA, 4'b0001, "ram_wr_lane0_prewrite");
        cycle(32'h10, 32'd0,         4'h0,    "ram_rd_merged");
        cycle(32'h13, 32'd0,         4'h0,    "ram_rd_unaligned");

        // Timer write and wrap.
        cycle(Mmio + 0, 32'hFFFF_FFFE, 4'hF, "mtime_lo_wr_hold");
        cycle(Mmio + 4, 32'hFFFF_FFFF, 4'hF, "mtime_hi_wr_hold");
        for (int i = 0; i < 3; i++) cycle(Mmio + 0, 32'd0, 4'h0, "mtime_wrap_lo");
        cycle(Mmio + 4, 32'd0, 4'h0, "mtime_wrap_hi");

        // Timer interrupt rise and fall.
        cycle(Mmio + 12, 32'd0, 4'hF, "cmp_hi_zero");
        cmp_lo = m_time[31:0] + 32'd5;
        cycle(Mmio + 8, cmp_lo, 4'hF, "cmp_lo_wr");
        for (int i = 0; i < 7; i++) cycle(Mmio + 0, 32'd0, 4'h0, "irq_watch");
        cycle(Mmio + 12, 32'd1, 4'hF, "cmp_hi_one");
        cycle(Mmio + 12, 32'd0, 4'h0, "irq_fell");

        // Random traffic; tohost stays out so the halt scenario starts clean.
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 3));
            if (kind <= 1) begin
                a = $urandom_range(0, 255);
            end else if (kind == 2) begin
                offs = int'($urandom_range(0, 6));
                if (offs >= 4) offs++;
                a = Mmio + 32'(offs * 4) + 32'($urandom_range(0, 3));
            end else begin
                a = $urandom_range(32'h0000_1000, 32'h7FFF_FFFF);
            end
            cycle(a, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, "rand");
        end

        // Faults and reserved offsets.
        cycle(32'h4000_0000, 32'hFFFF_FFFF, 4'hF, "fault_wr");
        cycle(32'h4000_0000, 32'd0,         4'h0, "fault_rd");
        cycle(Mmio + 32'h18, 32'hFFFF_FFFF, 4'hF, "reserved_wr");
        cycle(Mmio + 32'h18, 32'd0,         4'h0, "reserved_rd");
        cycle(32'h10, 32'd0, 4'h0, "ram_after_fault");

        // Halt via tohost.
        cycle(Mmio + 16, 32'd0, 4'hF, "tohost_zero");
        cycle(Mmio + 16, 32'd0, 4'h0, "tohost_zero_nohalt");
        cycle(Mmio + 16, 32'd1, 4'hF, "tohost_one");
        cycle(Mmio + 16, 32'd5, 4'hF, "tohost_five_ignored");
        cycle(Mmio + 16, 32'd0, 4'h0, "tohost_stays_one");
        cycle(Mmio + 0,  32'd0, 4'h0, "timer_runs_halted");

        // Asynchronous reset between edges.
        d_addr  = Mmio + 0;
        d_wdata = 32'd0;
        d_wstrb = 4'h0;
        #1;
        reset_n = 1'b0;
        model_reset();
        push_exp("async_reset");
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        model_edge(d_addr, d_wdata, d_wstrb);
        #1;
        cycle(Mmio + 8,  32'd0, 4'h0, "post_reset_cmp_lo");
        cycle(Mmio + 12, 32'd0, 4'h0, "post_reset_cmp_hi");
        cycle(Mmio + 0,  32'd0, 4'h0, "post_reset_mtime");

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_total++;
        if (q.size() != 0)
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        else
            n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
